// File: rtl/exec_pkg.sv
// exec_pkg: shared constants for the DLX execute stage.
//   - ALUCtrl encodings (ALU_ADD .. ALU_PASSB; code 15 yields zero)
//   - execute FSM state encoding (IDLE, MUL, DONE)
//   - alu_has_of(): true for the ops whose overflow flag is meaningful
package exec_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SEQ   = 4'd8;
  localparam logic [3:0] ALU_SNE   = 4'd9;
  localparam logic [3:0] ALU_SLT   = 4'd10;
  localparam logic [3:0] ALU_SGT   = 4'd11;
  localparam logic [3:0] ALU_SLE   = 4'd12;
  localparam logic [3:0] ALU_SGE   = 4'd13;
  localparam logic [3:0] ALU_PASSB = 4'd14;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic alu_has_of(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/execute_mc_mul_iter.sv
// mul_iter: iterative radix-2^MUL_BPC shift-add multiplier (low word only).
//   clk, reset : clock, synchronous active-high reset
//   start      : latch X/Y, clear accumulator, begin iterating
//   abort      : drop the running multiply (partial product discarded)
//   X, Y       : multiplicand / multiplier
//   busy       : an iteration runs this cycle
//   done       : this cycle performs the final iteration; Z is final after the edge
//   Z          : accumulator = low DATA_W bits of X*Y once finished
// The low word of a product is the same for signed and unsigned operands,
// so the unit works purely unsigned. Latency is fixed: no early exit.
module mul_iter #(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Z
);

  localparam int N_MUL = DATA_W / MUL_BPC;
  localparam int CW    = $clog2(N_MUL + 1);

  logic [DATA_W-1:0] mcand_reg;
  logic [DATA_W-1:0] mplier_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [CW-1:0]     cnt_reg;
  logic              busy_reg;

  // Partial-sum chain: each stage adds the multiplicand shifted by the
  // bit position when the corresponding multiplier digit bit is set.
  logic [DATA_W-1:0] pp [MUL_BPC+1];

  assign pp[0] = acc_reg;

  for (genvar gi = 0; gi < MUL_BPC; gi++) begin : g_pp
    assign pp[gi+1] = pp[gi] + (mplier_reg[gi] ? (mcand_reg << gi) : '0);
  end

  assign busy = busy_reg;
  assign done = busy_reg && (cnt_reg == CW'(N_MUL - 1));
  assign Z    = acc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (abort) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      mcand_reg  <= X;
      mplier_reg <= Y;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= pp[MUL_BPC];
      mcand_reg  <= mcand_reg << MUL_BPC;
      mplier_reg <= mplier_reg >> MUL_BPC;
      cnt_reg    <= cnt_reg + CW'(1);
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_mc.sv
// execute_mc: registered DLX execute stage with an iterative multiplier.
//   Inputs : clk, reset (sync, active-high), in_valid, flush, nextPC, opA,
//            opB, offset26, offset16, destReg, ALUCtrl, mul, jump, branch,
//            branchZero, regToPC
//   Outputs: stall (combinational), ex_valid, aluResult, of, leap, leapAddr,
//            destReg_out (all registered except stall)
// Data-width buses are numbered with bit 0 as the MSB. Single-cycle ops
// complete one edge after presentation; a multiply holds the front of the
// pipe (stall) through IDLE+MUL and retires from DONE, N_MUL+2 edges after
// first presentation. Requires DATA_W >= 26 for the jump immediate.
module execute_mc
  import exec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [0:DATA_W-1] nextPC,
  input  logic [0:DATA_W-1] opA,
  input  logic [0:DATA_W-1] opB,
  input  logic [25:0]       offset26,
  input  logic [15:0]       offset16,
  input  logic [4:0]        destReg,
  input  logic [3:0]        ALUCtrl,
  input  logic              mul,
  input  logic              jump,
  input  logic              branch,
  input  logic              branchZero,
  input  logic              regToPC,
  output logic              stall,
  output logic              ex_valid,
  output logic [0:DATA_W-1] aluResult,
  output logic              of,
  output logic              leap,
  output logic [0:DATA_W-1] leapAddr,
  output logic [4:0]        destReg_out
);

  localparam int SHW = $clog2(DATA_W);
  localparam int MSB = DATA_W - 1;

  // Internal arithmetic works on conventionally numbered copies; the
  // numeric value is unchanged by the port numbering.
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W-1:0] npc_val;
  logic [SHW-1:0]    shamt;

  assign a_val   = opA;
  assign b_val   = opB;
  assign npc_val = nextPC;
  // Least-significant log2(DATA_W) bits of opB under MSB-first numbering.
  assign shamt   = opB[DATA_W-SHW:DATA_W-1];

  // ---------------- ALU ----------------
  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] sub_res;
  logic              add_of;
  logic              sub_of;
  logic [DATA_W-1:0] alu_res;
  logic              alu_of;

  assign add_res = a_val + b_val;
  assign sub_res = a_val - b_val;
  assign add_of  = (a_val[MSB] == b_val[MSB]) && (add_res[MSB] != a_val[MSB]);
  assign sub_of  = (a_val[MSB] != b_val[MSB]) && (sub_res[MSB] != a_val[MSB]);

  always_comb begin
    alu_res = '0;
    unique case (ALUCtrl)
      ALU_ADD:   alu_res = add_res;
      ALU_SUB:   alu_res = sub_res;
      ALU_AND:   alu_res = a_val & b_val;
      ALU_OR:    alu_res = a_val | b_val;
      ALU_XOR:   alu_res = a_val ^ b_val;
      ALU_SLL:   alu_res = a_val << shamt;
      ALU_SRL:   alu_res = a_val >> shamt;
      ALU_SRA:   alu_res = $signed(a_val) >>> shamt;
      ALU_SEQ:   alu_res = {{(DATA_W-1){1'b0}}, (a_val == b_val)};
      ALU_SNE:   alu_res = {{(DATA_W-1){1'b0}}, (a_val != b_val)};
      ALU_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_val) <  $signed(b_val))};
      ALU_SGT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_val) >  $signed(b_val))};
      ALU_SLE:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_val) <= $signed(b_val))};
      ALU_SGE:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_val) >= $signed(b_val))};
      ALU_PASSB: alu_res = b_val;
      default:   alu_res = '0;
    endcase
  end

  assign alu_of = alu_has_of(ALUCtrl) && ((ALUCtrl == ALU_ADD) ? add_of : sub_of);

  // ---------------- leap resolution ----------------
  logic [DATA_W-1:0] imm;
  logic              leap_c;
  logic [DATA_W-1:0] leap_addr_c;

  assign imm = branch ? {{(DATA_W-16){offset16[15]}}, offset16}
                      : {{(DATA_W-26){offset26[25]}}, offset26};
  assign leap_c      = jump || (branch && ((a_val == '0) == branchZero));
  assign leap_addr_c = regToPC ? a_val : (npc_val + imm);

  // ---------------- multiplier ----------------
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_z;

  logic [1:0] state_reg;
  logic [1:0] state_next;

  assign mul_start = (state_reg == IDLE) && in_valid && mul && !flush;

  mul_iter #(
    .DATA_W  (DATA_W),
    .MUL_BPC (MUL_BPC)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .abort (flush),
    .X     (a_val),
    .Y     (b_val),
    .busy  (mul_busy),
    .done  (mul_done),
    .Z     (mul_z)
  );

  // mul_busy is high exactly while the FSM sits in MUL, so it stands in for
  // that state in the stall term. Flush and reset always release the stall.
  assign stall = !reset && !flush &&
                 (((state_reg == IDLE) && in_valid && mul) || mul_busy);

  // ---------------- FSM ----------------
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (in_valid && mul) state_next = MUL;
        MUL:     if (mul_done) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- EX/MEM registers ----------------
  logic              ex_valid_reg;
  logic [DATA_W-1:0] alu_result_reg;
  logic              of_reg;
  logic              leap_reg;
  logic [DATA_W-1:0] leap_addr_reg;
  logic [4:0]        dest_reg_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      ex_valid_reg   <= 1'b0;
      alu_result_reg <= '0;
      of_reg         <= 1'b0;
      leap_reg       <= 1'b0;
      leap_addr_reg  <= '0;
      dest_reg_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      ex_valid_reg <= 1'b0;
      if (!flush) begin
        if ((state_reg == IDLE) && in_valid && !mul) begin
          ex_valid_reg   <= 1'b1;
          alu_result_reg <= alu_res;
          of_reg         <= alu_of;
          leap_reg       <= leap_c;
          leap_addr_reg  <= leap_addr_c;
          dest_reg_reg   <= destReg;
        end else if (state_reg == DONE) begin
          // Upstream is still presenting the multiply, so destReg is current.
          ex_valid_reg   <= 1'b1;
          alu_result_reg <= mul_z;
          of_reg         <= 1'b0;
          leap_reg       <= 1'b0;
          dest_reg_reg   <= destReg;
        end
      end
    end
  end

  assign ex_valid    = ex_valid_reg;
  assign aluResult   = alu_result_reg;
  assign of          = of_reg;
  assign leap        = leap_reg;
  assign leapAddr    = leap_addr_reg;
  assign destReg_out = dest_reg_reg;

endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: self-checking bench for execute_mc (DATA_W=32, MUL_BPC=4).
// Directed vector table for single-cycle ops, hand sequences for reset,
// multiply and flush, then randomized traffic against a behavioural model.
module tb_execute_mc;
  import exec_pkg::*;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, mul, jump, branch, branchZero, regToPC;
  logic [0:31] nextPC, opA, opB;
  logic [25:0] offset26;
  logic [15:0] offset16;
  logic [4:0]  destReg;
  logic [3:0]  ALUCtrl;
  logic        stall, ex_valid, of, leap;
  logic [0:31] aluResult, leapAddr;
  logic [4:0]  destReg_out;

  int errors = 0;
  int checks = 0;

  // model of the registered outputs
  logic [31:0] m_res, m_addr;
  logic        m_of, m_leap;
  logic [4:0]  m_dr;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, npc;
    logic [25:0] o26;
    logic [15:0] o16;
    logic        jump, branch, bz, rtp;
    logic [31:0] res;
    logic        ofl, leap;
    logic [31:0] addr;
  } vec_t;

  vec_t vq[$];

  execute_mc #(.DATA_W(32), .MUL_BPC(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
    .nextPC(nextPC), .opA(opA), .opB(opB), .offset26(offset26),
    .offset16(offset16), .destReg(destReg), .ALUCtrl(ALUCtrl), .mul(mul),
    .jump(jump), .branch(branch), .branchZero(branchZero), .regToPC(regToPC),
    .stall(stall), .ex_valid(ex_valid), .aluResult(aluResult), .of(of),
    .leap(leap), .leapAddr(leapAddr), .destReg_out(destReg_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_res"},  aluResult, m_res);
    chk({tag, "_of"},   32'(of), 32'(m_of));
    chk({tag, "_leap"}, 32'(leap), 32'(m_leap));
    chk({tag, "_addr"}, leapAddr, m_addr);
    chk({tag, "_dr"},   32'(destReg_out), 32'(m_dr));
  endtask

  // Behavioural reference: plain signed/unsigned arithmetic on wide ints.
  function automatic void ref_single(input vec_t v, output logic [31:0] res,
                                     output logic ofl, output logic lp,
                                     output logic [31:0] addr);
    longint sa, sb, s, p, imm;
    logic [63:0] wide;
    int sh;
    sa  = longint'($signed(v.a));
    sb  = longint'($signed(v.b));
    sh  = int'(v.b % 32);
    p   = longint'(1) << sh;
    res = '0;
    ofl = 1'b0;
    s   = 0;
    case (v.op)
      4'd0:  begin s = sa + sb; res = s[31:0]; ofl = (s > MAXS) || (s < MINS); end
      4'd1:  begin s = sa - sb; res = s[31:0]; ofl = (s > MAXS) || (s < MINS); end
      4'd2:  res = v.a & v.b;
      4'd3:  res = v.a | v.b;
      4'd4:  res = v.a ^ v.b;
      4'd5:  begin wide = 64'(v.a) * 64'(p); res = wide[31:0]; end
      4'd6:  begin s = longint'(v.a) / p; res = s[31:0]; end
      4'd7:  begin
               if (sa >= 0) s = sa / p;
               else         s = -((-sa + p - 1) / p);
               res = s[31:0];
             end
      4'd8:  res = (sa == sb) ? 32'd1 : 32'd0;
      4'd9:  res = (sa != sb) ? 32'd1 : 32'd0;
      4'd10: res = (sa <  sb) ? 32'd1 : 32'd0;
      4'd11: res = (sa >  sb) ? 32'd1 : 32'd0;
      4'd12: res = (sa <= sb) ? 32'd1 : 32'd0;
      4'd13: res = (sa >= sb) ? 32'd1 : 32'd0;
      4'd14: res = v.b;
      default: res = '0;
    endcase
    lp  = v.jump || (v.branch && ((v.a == 0) == v.bz));
    imm = v.branch ? longint'($signed(v.o16)) : longint'($signed(v.o26));
    if (v.rtp) addr = v.a;
    else begin s = longint'(v.npc) + imm; addr = s[31:0]; end
  endfunction

  // Present one single-cycle op, expect it registered one edge later.
  task automatic apply_op(input vec_t v, input logic [4:0] dr);
    in_valid = 1'b1; mul = 1'b0; flush = 1'b0;
    ALUCtrl = v.op; opA = v.a; opB = v.b; nextPC = v.npc;
    offset26 = v.o26; offset16 = v.o16; jump = v.jump; branch = v.branch;
    branchZero = v.bz; regToPC = v.rtp; destReg = dr;
    #1;
    chk("op_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("op_valid", 32'(ex_valid), 32'd1);
    m_res = v.res; m_of = v.ofl; m_leap = v.leap; m_addr = v.addr; m_dr = dr;
    chk_hold("op");
    $display("op %0d a=%h b=%h -> res=%h of=%b leap=%b addr=%h",
             v.op, v.a, v.b, aluResult, of, leap, leapAddr);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0; mul = 1'b0; flush = 1'b0;
    opA = $urandom; opB = $urandom; ALUCtrl = 4'($urandom);
    #1;
    chk("idle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("idle_valid", 32'(ex_valid), 32'd0);
    chk_hold("idle");
    $display("idle -> ex_valid=%b res=%h", ex_valid, aluResult);
  endtask

  // Multiply: stall for cycles 0..8, result at edge 10. flush_at in 0..9
  // asserts flush in that cycle instead; -1 runs to completion.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dr, input int flush_at);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    in_valid = 1'b1; mul = 1'b1; flush = 1'b0; jump = 1'b0; branch = 1'b0;
    regToPC = 1'b0; ALUCtrl = 4'($urandom); opA = a; opB = b; destReg = dr;
    for (int c = 0; c < 10; c++) begin
      if (c >= 1) begin opA = $urandom; opB = $urandom; end
      if (c == flush_at) begin
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_res", aluResult, m_res);
        $display("mul a=%h b=%h flushed at cycle %0d -> ex_valid=%b", a, b, c, ex_valid);
        flush = 1'b0; in_valid = 1'b0; mul = 1'b0;
        return;
      end
      #1;
      chk("mul_stall", 32'(stall), (c < 9) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      if (c < 9) chk("mul_early_valid", 32'(ex_valid), 32'd0);
    end
    chk("mul_valid", 32'(ex_valid), 32'd1);
    m_res = prod[31:0]; m_of = 1'b0; m_leap = 1'b0; m_dr = dr;
    chk_hold("mul");
    $display("mul a=%h b=%h -> res=%h ex_valid=%b", a, b, aluResult, ex_valid);
    in_valid = 1'b0; mul = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic ofl);
    vec_t v;
    v = '{op: op, a: a, b: b, npc: 32'h0, o26: 26'h0, o16: 16'h0, jump: 1'b0,
          branch: 1'b0, bz: 1'b0, rtp: 1'b0, res: res, ofl: ofl, leap: 1'b0, addr: 32'h0};
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [31:0] r_res, r_addr, ra, rb;
    logic r_of, r_leap;
    int kind;

    // ---- reset held 2 cycles with a multiply presented ----
    reset = 1'b1; in_valid = 1'b1; mul = 1'b1; flush = 1'b0; jump = 1'b0;
    branch = 1'b0; branchZero = 1'b0; regToPC = 1'b0; ALUCtrl = ALU_ADD;
    opA = 32'h1234; opB = 32'h5678; nextPC = 32'h0; offset26 = '0;
    offset16 = '0; destReg = 5'd3;
    m_res = '0; m_of = 1'b0; m_leap = 1'b0; m_addr = '0; m_dr = '0;
    #1;
    chk("rst_stall0", 32'(stall), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk_hold("rst");
      $display("reset cycle %0d -> ex_valid=%b stall=%b", i, ex_valid, stall);
    end
    reset = 1'b0;
    idle_cycle();

    // ---- directed single-cycle table ----
    vq.push_back(mk(ALU_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1));
    vq.push_back(mk(ALU_ADD,   32'h80000000, 32'h80000000, 32'h00000000, 1'b1));
    vq.push_back(mk(ALU_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1));
    vq.push_back(mk(ALU_SUB,   32'h00000005, 32'h00000003, 32'h00000002, 1'b0));
    vq.push_back(mk(ALU_AND,   32'hF0F0FFFF, 32'h0FF000FF, 32'h00F000FF, 1'b0));
    vq.push_back(mk(ALU_OR,    32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0));
    vq.push_back(mk(ALU_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0));
    vq.push_back(mk(ALU_SLL,   32'h00000001, 32'h00000024, 32'h00000010, 1'b0));
    vq.push_back(mk(ALU_SRL,   32'h80000000, 32'h0000001F, 32'h00000001, 1'b0));
    vq.push_back(mk(ALU_SRA,   32'h80000000, 32'hFFFFFFE4, 32'hF8000000, 1'b0));
    vq.push_back(mk(ALU_SEQ,   32'h00000005, 32'h00000005, 32'h00000001, 1'b0));
    vq.push_back(mk(ALU_SNE,   32'h00000005, 32'h00000005, 32'h00000000, 1'b0));
    vq.push_back(mk(ALU_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0));
    vq.push_back(mk(ALU_SGT,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0));
    vq.push_back(mk(ALU_SLE,   32'h00000003, 32'h00000003, 32'h00000001, 1'b0));
    vq.push_back(mk(ALU_SGE,   32'h00000002, 32'h00000003, 32'h00000000, 1'b0));
    vq.push_back(mk(ALU_PASSB, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b0));
    vq.push_back(mk(4'd15,     32'h00000001, 32'h00000002, 32'h00000000, 1'b0));
    // BEQZ taken, BEQZ not taken, BNEZ taken
    v = mk(ALU_ADD, 32'h0, 32'h0, 32'h0, 1'b0);
    v.npc = 32'h100; v.o16 = 16'hFFFC; v.branch = 1'b1; v.bz = 1'b1;
    v.leap = 1'b1; v.addr = 32'h000000FC; vq.push_back(v);
    v.a = 32'h5; v.res = 32'h5; v.leap = 1'b0; vq.push_back(v);
    v.bz = 1'b0; v.npc = 32'h200; v.o16 = 16'h0010; v.leap = 1'b1;
    v.addr = 32'h00000210; vq.push_back(v);
    // JR and JAL
    v = mk(ALU_ADD, 32'h00004000, 32'h0, 32'h00004000, 1'b0);
    v.jump = 1'b1; v.rtp = 1'b1; v.leap = 1'b1; v.addr = 32'h00004000; vq.push_back(v);
    v = mk(ALU_ADD, 32'h0, 32'h0, 32'h0, 1'b0);
    v.jump = 1'b1; v.npc = 32'h20; v.o26 = 26'h3FFFFFF; v.leap = 1'b1;
    v.addr = 32'h0000001F; vq.push_back(v);

    foreach (vq[i]) apply_op(vq[i], 5'(i));

    // ---- multiply -3 * 7, then ex_valid must drop after one cycle ----
    do_mul(32'hFFFFFFFD, 32'h00000007, 5'd9, -1);
    chk("mul_neg3x7", aluResult, 32'hFFFFFFEB);
    idle_cycle();

    // ---- flush in the 3rd MUL cycle, then an ADD completes in 1 cycle ----
    do_mul(32'h00001234, 32'h00005678, 5'd4, 3);
    apply_op(mk(ALU_ADD, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0), 5'd7);

    // ---- randomized traffic vs. model ----
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(9));
      if (kind == 0) begin
        idle_cycle();
      end else if (kind == 1) begin
        in_valid = 1'b1; mul = 1'($urandom); flush = 1'b1;
        opA = $urandom; opB = $urandom; ALUCtrl = 4'($urandom);
        #1;
        chk("rflush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("rflush_valid", 32'(ex_valid), 32'd0);
        chk_hold("rflush");
        $display("flush -> ex_valid=%b", ex_valid);
        flush = 1'b0;
      end else if (kind == 2) begin
        ra = ($urandom_range(3) == 0) ? 32'(signed'(int'($urandom_range(2)) - 1)) : $urandom;
        rb = ($urandom_range(3) == 0) ? 32'(signed'(int'($urandom_range(2)) - 1)) : $urandom;
        do_mul(ra, rb, 5'($urandom),
               ($urandom_range(2) == 0) ? int'($urandom_range(9)) : -1);
      end else begin
        v.op = 4'($urandom); v.a = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
        v.b = $urandom; v.npc = $urandom; v.o26 = 26'($urandom);
        v.o16 = 16'($urandom); v.jump = 1'($urandom);
        v.branch = ($urandom_range(1) == 0) ? 1'b0 : ~v.jump; v.bz = 1'($urandom);
        v.rtp = v.jump & 1'($urandom);
        ref_single(v, r_res, r_of, r_leap, r_addr);
        v.res = r_res; v.ofl = r_of; v.leap = r_leap; v.addr = r_addr;
        apply_op(v, 5'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
